// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the DDR port arbiter and its round-robin selector.
package ddr_arb_pkg;

    localparam int ID_BITS   = 2;
    localparam int DATA_BITS = 32;
    localparam int STRB_BITS = 4;
    localparam int LEN_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RDATA = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping mod NUM_PORTS.
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_BITS-1:0]   ptr,
    output logic [ID_BITS-1:0]   grant,
    output logic                 any
);

    always_comb begin
        int idx;
        idx   = 0;
        any   = 1'b0;
        grant = '0;
        // Walk from the farthest offset back to ptr so the closest requester wins.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                any   = 1'b1;
                grant = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin sharing of the DDR controller's single AXI-style port; one transaction in flight.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 27
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             s_arw_valid,
    output logic [NUM_PORTS-1:0]             s_arw_ready,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]   s_arw_addr,
    input  logic [NUM_PORTS*LEN_BITS-1:0]    s_arw_len,
    input  logic [NUM_PORTS-1:0]             s_arw_write,
    input  logic [NUM_PORTS-1:0]             s_wvalid,
    output logic [NUM_PORTS-1:0]             s_wready,
    input  logic [NUM_PORTS-1:0]             s_wlast,
    input  logic [NUM_PORTS*DATA_BITS-1:0]   s_wdata,
    input  logic [NUM_PORTS*STRB_BITS-1:0]   s_wstrb,
    output logic [NUM_PORTS-1:0]             s_bvalid,
    input  logic [NUM_PORTS-1:0]             s_bready,
    output logic [NUM_PORTS-1:0]             s_rvalid,
    output logic [NUM_PORTS-1:0]             s_rlast,
    output logic [DATA_BITS-1:0]             s_rdata,
    output logic                             m_arw_valid,
    input  logic                             m_arw_ready,
    output logic [ADDR_BITS-1:0]             m_arw_addr,
    output logic [LEN_BITS-1:0]              m_arw_len,
    output logic                             m_arw_write,
    output logic [ID_BITS-1:0]               m_arw_id,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    output logic                             m_wlast,
    output logic [DATA_BITS-1:0]             m_wdata,
    output logic [STRB_BITS-1:0]             m_wstrb,
    input  logic                             m_bvalid,
    output logic                             m_bready,
    input  logic [ID_BITS-1:0]               m_bid,
    input  logic                             m_rvalid,
    input  logic                             m_rlast,
    input  logic [DATA_BITS-1:0]             m_rdata,
    input  logic [ID_BITS-1:0]               m_rid,
    output logic                             m_rready,
    output logic                             id_error
);

    arb_state_e           state_q, state_d;
    logic [ID_BITS-1:0]   grant_q, grant_d;
    logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 id_error_q, id_error_d;

    logic [ID_BITS-1:0]   pick_grant;
    logic                 pick_any;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic                 sel_wvalid, sel_bready;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req   (s_arw_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign gnt_oh = NUM_PORTS'(1) << grant_q;

    // Per-port fields muxed by the latched grant, compared against constant port numbers.
    always_comb begin
        m_arw_addr  = '0;
        m_arw_len   = '0;
        m_arw_write = 1'b0;
        sel_wvalid  = 1'b0;
        m_wlast     = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        sel_bready  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == ID_BITS'(p)) begin
                m_arw_addr  = s_arw_addr[p*ADDR_BITS +: ADDR_BITS];
                m_arw_len   = s_arw_len[p*LEN_BITS +: LEN_BITS];
                m_arw_write = s_arw_write[p];
                sel_wvalid  = s_wvalid[p];
                m_wlast     = s_wlast[p];
                m_wdata     = s_wdata[p*DATA_BITS +: DATA_BITS];
                m_wstrb     = s_wstrb[p*STRB_BITS +: STRB_BITS];
                sel_bready  = s_bready[p];
            end
        end
    end

    assign m_arw_valid = (state_q == ADDR);
    assign m_arw_id    = grant_q;
    assign m_wvalid    = (state_q == WDATA) && sel_wvalid;
    assign m_bready    = (state_q == WRESP) && sel_bready;
    assign m_rready    = 1'b1;
    assign s_rdata     = m_rdata;
    assign id_error    = id_error_q;

    assign s_arw_ready = (state_q == ADDR  && m_arw_ready) ? gnt_oh : '0;
    assign s_wready    = (state_q == WDATA && m_wready)    ? gnt_oh : '0;
    assign s_bvalid    = (state_q == WRESP && m_bvalid)    ? gnt_oh : '0;
    assign s_rvalid    = (state_q == RDATA && m_rvalid)    ? gnt_oh : '0;
    assign s_rlast     = (state_q == RDATA && m_rlast)     ? gnt_oh : '0;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        id_error_d = id_error_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_arw_ready) begin
                    rr_ptr_d = (grant_q == ID_BITS'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = m_arw_write ? WDATA : RDATA;
                end
            end
            WDATA: begin
                // An early wlast ends the burst; the controller stops on it too.
                if (m_wvalid && m_wready && m_wlast) state_d = WRESP;
            end
            WRESP: begin
                if (m_bvalid && m_bready) begin
                    if (m_bid != grant_q) id_error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (m_rvalid) begin
                    if (m_rid != grant_q) id_error_d = 1'b1;
                    if (m_rlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            id_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            id_error_q <= id_error_d;
        end
    end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single AXI4-style port of the DDR SDRAM controller between NUM_PORTS requesters (CPU I-fetch, CPU D-side, video DMA, ...).
- Round-robin arbitration on the combined address/write channel; one transaction is in flight at a time, because the controller serialises anyway.
- Forwards W, B and R beats to and from the granted requester only.
- Drives the controller's 2-bit arw_id with the granted port index and checks the returned bid/rid against it.

Parameters:
- NUM_PORTS, 2, number of requesters; legal range 2..4 (fits the 2-bit id).
- ADDR_BITS, 27, byte-address width; equals ROW_BITS+COL_BITS+3 of the controller.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_arw_valid  in  NUM_PORTS  per-port request valid
- s_arw_ready  out  NUM_PORTS  per-port request accept
- s_arw_addr  in  NUM_PORTS*ADDR_BITS  port p at slice [p*ADDR_BITS +: ADDR_BITS]
- s_arw_len  in  NUM_PORTS*8  beats minus one
- s_arw_write  in  NUM_PORTS  1 = write, 0 = read
- s_wvalid  in  NUM_PORTS  write-data valid
- s_wready  out  NUM_PORTS  write-data ready
- s_wlast  in  NUM_PORTS  last write beat
- s_wdata  in  NUM_PORTS*32  write data
- s_wstrb  in  NUM_PORTS*4  byte strobes
- s_bvalid  out  NUM_PORTS  write response valid
- s_bready  in  NUM_PORTS  write response ready
- s_rvalid  out  NUM_PORTS  read beat valid
- s_rlast  out  NUM_PORTS  last read beat
- s_rdata  out  32  read data, broadcast to all ports
- m_arw_valid, m_arw_ready, m_arw_addr[ADDR_BITS], m_arw_len[8], m_arw_write, m_arw_id[2]  controller address channel (directions mirrored)
- m_wvalid, m_wready, m_wlast, m_wdata[32], m_wstrb[4]  controller write channel
- m_bvalid, m_bready, m_bid[2]  controller write response
- m_rvalid, m_rlast, m_rdata[32], m_rid[2]  controller read channel
- m_rready  out  1  tied to 1
- id_error  out  1  sticky flag: returned bid/rid did not match the grant

Behaviour:
- Reset values:
  - state IDLE; grant=0; rr_ptr=0; id_error=0.
  - All s_* ready/valid outputs 0; m_arw_valid=0, m_wvalid=0, m_bready=0.
- FSM states: IDLE, ADDR, WDATA, WRESP, RDATA.
- IDLE:
  - If any s_arw_valid is set, grant the first requesting port at or after rr_ptr, with circular wrap (mod NUM_PORTS).
  - Register grant and go to ADDR.
  - No s_arw_ready is asserted in IDLE.
- ADDR:
  - m_arw_valid=1, with m_arw_addr/len/write muxed from the port selected by grant; m_arw_id=grant.
  - s_arw_ready[grant]=m_arw_ready; all other ports get 0.
  - On handshake: rr_ptr <= grant+1 (mod NUM_PORTS), then go to WDATA if write else RDATA.
  - Minimum request-to-controller latency: 1 cycle (s_arw_valid at cycle N gives m_arw_valid at N+1).
- WDATA:
  - m_wvalid=s_wvalid[grant]; m_wdata/wstrb/wlast muxed from grant; s_wready[grant]=m_wready; other ports 0.
  - On handshake with wlast=1, go to WRESP. An early wlast (before len+1 beats) is legal; the controller also terminates on it.
- WRESP:
  - s_bvalid[grant]=m_bvalid; m_bready=s_bready[grant].
  - On handshake: if m_bid!=grant, set id_error; go to IDLE.
- RDATA:
  - s_rvalid[grant]=m_rvalid and s_rlast[grant]=m_rlast; other ports 0. s_rdata=m_rdata always.
  - The controller cannot stall R, so requesters must accept every beat and s_rready does not exist.
  - On m_rvalid with m_rid!=grant, set id_error.
  - On m_rvalid && m_rlast, go to IDLE.
- Boundary conditions:
  - A request dropped before handshake is a protocol violation; the arbiter keeps presenting the latched grant.
  - All ports requesting continuously: each is served once per NUM_PORTS transactions, with no starvation.
  - Single requester: back-to-back transactions with 1 IDLE cycle between them.
  - rr_ptr wraps NUM_PORTS-1 -> 0.
  - Reset mid-transaction: all outputs return to reset values next cycle and the controller is also reset by the system; id_error clears only on reset.

Decomposition:
- Package ddr_arb_pkg: state encoding constants (IDLE..RDATA), ID_BITS=2, DATA_BITS=32, STRB_BITS=4, LEN_BITS=8.
- One sub-module, rr_pick: combinational round-robin selector (request vector + pointer -> grant index + any). It is reused by the future video/DMA arbiters.

Test Plan:
- Port 1 write, addr 0x100, len 3, 4 beats 0xA0..0xA3 -> m_arw_id=1; m_wdata sequence A0..A3; s_bvalid[1] pulses exactly once; port 0 sees no ready/valid.
- Ports 0 and 1 read simultaneously, len 1 each -> port 0 served first, then port 1. Each gets 2 s_rvalid beats with s_rlast on the 2nd; rr_ptr ends at 0.
- All ports request continuously for 8 transactions -> grant order 0,1,0,1,... (NUM_PORTS=2), or 0,1,2,3,0,... for NUM_PORTS=4.
- Write with wlast on beat 2 of len 7 -> FSM enters WRESP after 2 beats; the next request is granted after the B handshake.
- Model returns m_rid=2 while grant=0 -> id_error=1 and stays 1 until reset.
- Assert reset while in WDATA -> next cycle all s_wready, m_wvalid and m_arw_valid are 0 and state is IDLE; a fresh port-1 request is then granted first.
